// File: rtl/noise_gate.sv
// Noise gate: envelope follower plus a five-state gain FSM that fades the sample
// stream in and out. Two-cycle pipeline from vld_i to vld_o, one sample per cycle.
// Optional build macro NOISE_GATE_HYST_EN: when defined, the open gate starts
// closing below THRESH_CLOSE (hysteresis); otherwise it uses THRESH_OPEN.
module noise_gate #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned THRESH_OPEN  = 16,
    parameter int unsigned THRESH_CLOSE = 8,
    parameter int unsigned HOLD_SAMPLES = 64,
    parameter int unsigned ATTACK_STEP  = 16,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned ENV_DECAY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  vld_o
);

    localparam int unsigned PW = DATA_WIDTH + 7;
    localparam int unsigned CW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

    localparam logic [DATA_WIDTH-1:0] ThreshOpen = DATA_WIDTH'(THRESH_OPEN);
    localparam logic [DATA_WIDTH-1:0] EnvDecay   = DATA_WIDTH'(ENV_DECAY);
    localparam logic [9:0]            AttStep    = 10'(ATTACK_STEP);
    localparam logic [8:0]            RelStep    = 9'(RELEASE_STEP);
    localparam logic [8:0]            GainUnity  = 9'd128;
    localparam logic [CW-1:0]         HoldInit   = CW'(HOLD_SAMPLES);

`ifdef NOISE_GATE_HYST_EN
    localparam logic [DATA_WIDTH-1:0] ThreshHold = DATA_WIDTH'(THRESH_CLOSE);
`else
    // Without hysteresis the close threshold is deliberately ignored.
    localparam logic [DATA_WIDTH-1:0] ThreshHold = DATA_WIDTH'(THRESH_OPEN);
    localparam int unsigned unused_thresh_close = THRESH_CLOSE;
`endif

    typedef enum logic [2:0] {
        StClosed,
        StAttack,
        StOpen,
        StHold,
        StRelease
    } state_e;

    state_e                  state_q, state_d;
    logic [8:0]              g_q, g_d;
    logic [DATA_WIDTH-1:0]   env_q, env_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   mag;
    logic [DATA_WIDTH-1:0]   env_dec;
    logic [DATA_WIDTH-1:0]   env_new;
    logic [9:0]              g_att_sum;
    logic signed [PW-1:0]    prod;
    logic                    unused_prod;

    logic                    s1_vld_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;

    // Saturating magnitude and decayed envelope of the incoming sample.
    always_comb begin
        mag = data_i;
        if (data_i[DATA_WIDTH-1]) begin
            if (data_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
                mag = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                mag = -data_i;
            end
        end
        env_dec   = (env_q > EnvDecay) ? (env_q - EnvDecay) : '0;
        env_new   = (mag > env_dec) ? mag : env_dec;
        g_att_sum = {1'b0, g_q} + AttStep;
    end

    // Sample times the pre-update gain; g <= 128 so PW bits cannot overflow.
    always_comb begin
        prod = PW'($signed(data_i)) * PW'($signed({1'b0, g_q}));
    end

    assign unused_prod = ^prod[6:0];

    // Next-state logic for gain FSM; everything holds when no valid sample.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        env_d   = env_q;
        cnt_d   = cnt_q;
        if (vld_i) begin
            env_d = env_new;
            case (state_q)
                StClosed: begin
                    g_d = '0;
                    if (env_new >= ThreshOpen) begin
                        state_d = StAttack;
                    end
                end
                StAttack: begin
                    if (g_att_sum >= {1'b0, GainUnity}) begin
                        g_d     = GainUnity;
                        state_d = StOpen;
                    end else begin
                        g_d = g_att_sum[8:0];
                    end
                end
                StOpen: begin
                    g_d = GainUnity;
                    if (env_new < ThreshHold) begin
                        state_d = StHold;
                        cnt_d   = HoldInit;
                    end
                end
                StHold: begin
                    // Re-trigger wins over hold expiry.
                    if (env_new >= ThreshOpen) begin
                        state_d = StOpen;
                    end else if (cnt_q == '0) begin
                        state_d = StRelease;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StRelease: begin
                    if (env_new >= ThreshOpen) begin
                        state_d = StAttack;
                    end else begin
                        g_d = (g_q > RelStep) ? (g_q - RelStep) : '0;
                        if (g_d == '0) begin
                            state_d = StClosed;
                        end
                    end
                end
                default: begin
                    state_d = StClosed;
                    g_d     = '0;
                end
            endcase
        end
    end

    // Gain FSM state, envelope and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClosed;
            g_q     <= '0;
            env_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
        end
    end

    // Two-stage output pipeline; data registers only load on valid so data_o holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            vld_o     <= 1'b0;
            data_o    <= '0;
        end else begin
            s1_vld_q <= vld_i;
            if (vld_i) begin
                s1_data_q <= prod[PW-1:7];
            end
            vld_o <= s1_vld_q;
            if (s1_vld_q) begin
                data_o <= s1_data_q;
            end
        end
    end

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: directed scenarios plus a randomized
// stream, all compared against a sample-level reference model.
module tb_noise_gate;

    localparam int DW      = 8;
    localparam int T_OPEN  = 16;
    localparam int T_CLOSE = 8;
    localparam int HOLD    = 64;
    localparam int ATT     = 16;
    localparam int REL     = 1;
    localparam int DECAY   = 1;

    localparam int M_CLOSED  = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_OPEN    = 2;
    localparam int M_HOLD    = 3;
    localparam int M_RELEASE = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] data_i;
    logic                 vld_i;
    logic signed [DW-1:0] data_o;
    logic                 vld_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int m_env, m_g, m_cnt, m_mode;
    int s1v, s1d, s2v, s2d;

    always #5 clk = ~clk;

    noise_gate #(
        .DATA_WIDTH  (DW),
        .THRESH_OPEN (T_OPEN),
        .THRESH_CLOSE(T_CLOSE),
        .HOLD_SAMPLES(HOLD),
        .ATTACK_STEP (ATT),
        .RELEASE_STEP(REL),
        .ENV_DECAY   (DECAY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data_i(data_i),
        .vld_i (vld_i),
        .data_o(data_o),
        .vld_o (vld_o)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_env  = 0;
        m_g    = 0;
        m_cnt  = 0;
        m_mode = M_CLOSED;
        s1v    = 0;
        s1d    = 0;
        s2v    = 0;
        s2d    = 0;
    endfunction

    // One valid sample through the gate rules; returns the gated output.
    function automatic int model_step(input int d);
        int a, dec, envn, out, thr;
        a    = (d < 0) ? ((d == -128) ? 127 : -d) : d;
        dec  = m_env - DECAY;
        if (dec < 0) dec = 0;
        envn = (a > dec) ? a : dec;
        out  = (d * m_g) >>> 7;
`ifdef NOISE_GATE_HYST_EN
        thr = T_CLOSE;
`else
        thr = T_OPEN;
`endif
        m_env = envn;
        if (m_mode == M_CLOSED) begin
            m_g = 0;
            if (envn >= T_OPEN) m_mode = M_ATTACK;
        end else if (m_mode == M_ATTACK) begin
            m_g = m_g + ATT;
            if (m_g >= 128) begin
                m_g    = 128;
                m_mode = M_OPEN;
            end
        end else if (m_mode == M_OPEN) begin
            m_g = 128;
            if (envn < thr) begin
                m_mode = M_HOLD;
                m_cnt  = HOLD;
            end
        end else if (m_mode == M_HOLD) begin
            if (envn >= T_OPEN) m_mode = M_OPEN;
            else if (m_cnt == 0) m_mode = M_RELEASE;
            else m_cnt = m_cnt - 1;
        end else begin
            if (envn >= T_OPEN) begin
                m_mode = M_ATTACK;
            end else begin
                m_g = m_g - REL;
                if (m_g <= 0) begin
                    m_g    = 0;
                    m_mode = M_CLOSED;
                end
            end
        end
        return out;
    endfunction

    // Drive one cycle, advance the model, check both outputs just after the edge.
    task automatic tick(input int d, input bit v);
        data_i = d[DW-1:0];
        vld_i  = v;
        @(posedge clk);
        if (s1v != 0) s2d = s1d;
        s2v = s1v;
        if (v) s1d = model_step(d);
        s1v = v ? 1 : 0;
        #1;
        check("vld_o", {31'b0, vld_o}, s2v);
        check("data_o", data_o, s2d);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_data", data_o, 0);
        check("rst_vld", {31'b0, vld_o}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int seq[12];
        int kind;
        int d;
        bit v;
        seq = '{0, 0, 12, 25, 37, 50, 62, 75, 87, 100, 100, 100};

        rst    = 1'b1;
        vld_i  = 1'b0;
        data_i = '0;
        model_reset();
        #12;
        check("por_data", data_o, 0);
        check("por_vld", {31'b0, vld_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Quiet stream keeps gate closed.
        for (int i = 0; i < 10; i++) tick(5, 1'b1);
        check("quiet_closed", data_o, 0);

        // Opening ramp from a closed gate.
        for (int i = 0; i <= 12; i++) begin
            tick(100, 1'b1);
            if (i >= 1) check("open_seq", data_o, seq[i-1]);
        end

        // Most-negative sample at unity gain.
        for (int i = 0; i < 4; i++) tick(-128, 1'b1);
        check("neg_full", data_o, -128);

        // Envelope settles at 12: hysteresis decides whether the gate stays open.
        for (int i = 0; i < 400; i++) tick(12, 1'b1);
`ifdef NOISE_GATE_HYST_EN
        check("hyst_hold", data_o, 12);
`else
        check("hyst_hold", data_o, 0);
`endif

        // Reopen, then let a low-level stream decay through HOLD and RELEASE.
        for (int i = 0; i < 12; i++) tick(100, 1'b1);
        check("reopen", data_o, 100);
        for (int i = 0; i < 400; i++) tick(7, 1'b1);
        check("closed_after_release", data_o, 0);

        // Mid-ATTACK reset, then gapped valid pattern.
        for (int i = 0; i < 3; i++) tick(100, 1'b1);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick(100, (k % 2) == 0);
            if (k >= 1) check("gap_vld", {31'b0, vld_o}, ((k - 1) % 2) == 0 ? 1 : 0);
        end

        // Randomized segments of loud, quiet and silent material with gaps.
        kind = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) kind = $urandom_range(0, 2);
            if (i == 1500) do_reset();
            if (kind == 0) d = int'($urandom_range(0, 255)) - 128;
            else if (kind == 1) d = int'($urandom_range(0, 14)) - 7;
            else d = 0;
            v = ($urandom_range(0, 9) < 8);
            tick(d, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
